// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage R/I/J CPU control blocks.
// Holds opcode constants, instruction field positions, the issue
// scoreboard entry type and the issue controller state encoding.
package cpu_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'h00;
  localparam logic [5:0]  OP_LW    = 6'h23;
  localparam logic [5:0]  OP_SW    = 6'h2b;
  localparam logic [5:0]  OP_BEQ   = 6'h04;
  localparam logic [5:0]  OP_J     = 6'h02;
  localparam logic [31:0] NOP_WORD = 32'hffff_ffff;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t dest;
  } sb_entry_t;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_BR_WAIT = 1'b1
  } issue_state_t;

endpackage

// File: rtl/issue_ctrl_if.sv
// Handshake bundle between the IF/ID slot and the issue controller.
// master: fetch side, drives if_valid/IR_IF and observes the decisions.
// slave : issue controller, consumes the slot and drives enables,
//         hazard/hold status and the lost-cycle counters.
interface issue_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             if_valid;
  logic [31:0]      IR_IF;
  logic             issue;
  logic             pc_we;
  logic             ifid_we;
  logic             idex_bubble;
  logic             hasHazard;
  logic             br_hold;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] br_cnt;

  modport master (
    output if_valid, IR_IF,
    input  issue, pc_we, ifid_we, idex_bubble, hasHazard, br_hold,
           stall_cnt, br_cnt
  );

  modport slave (
    input  if_valid, IR_IF,
    output issue, pc_we, ifid_we, idex_bubble, hasHazard, br_hold,
           stall_cnt, br_cnt
  );
endinterface

// File: rtl/instr_decode.sv
// Combinational register-usage decode of one instruction word.
// Ports:
//   ir        in  32 : instruction word
//   rs, rt    out 5  : source register fields
//   use_rs/rt out 1  : source is read and is not $0
//   wr_en     out 1  : instruction writes a register other than $0
//   wr_reg    out 5  : destination register (rd for R-type, rt for lw)
//   is_branch out 1  : beq or j
module instr_decode
  import cpu_pkg::*;
(
  input  logic [31:0] ir,
  output reg_idx_t    rs,
  output reg_idx_t    rt,
  output logic        use_rs,
  output logic        use_rt,
  output logic        wr_en,
  output reg_idx_t    wr_reg,
  output logic        is_branch
);

  logic [5:0] op;
  reg_idx_t   rd;
  logic       reads_rs;
  logic       reads_rt;
  logic       writes;

  assign op = ir[OP_MSB:OP_LSB];
  assign rs = ir[RS_MSB:RS_LSB];
  assign rt = ir[RT_MSB:RT_LSB];
  assign rd = ir[RD_MSB:RD_LSB];

  always_comb begin
    reads_rs  = 1'b0;
    reads_rt  = 1'b0;
    writes    = 1'b0;
    wr_reg    = '0;
    is_branch = 1'b0;
    if (ir != NOP_WORD) begin
      case (op)
        OP_RTYPE: begin
          reads_rs = 1'b1;
          reads_rt = 1'b1;
          writes   = 1'b1;
          wr_reg   = rd;
        end
        OP_LW: begin
          reads_rs = 1'b1;
          writes   = 1'b1;
          wr_reg   = rt;
        end
        OP_SW: begin
          reads_rs = 1'b1;
          reads_rt = 1'b1;
        end
        OP_BEQ: begin
          reads_rs  = 1'b1;
          reads_rt  = 1'b1;
          is_branch = 1'b1;
        end
        OP_J: begin
          is_branch = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // $0 is hardwired to zero, so it can neither produce nor suffer a hazard.
  assign use_rs = reads_rs && (rs != '0);
  assign use_rt = reads_rt && (rt != '0);
  assign wr_en  = writes && (wr_reg != '0);

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller between IF and ID. Tracks destinations of in-flight
// instructions (ID/EX/MEM) in a shift scoreboard, stalls on RAW hazards
// (no forwarding), holds fetch for BR_PENALTY cycles after a branch
// issues, and counts RAW-stall and branch-hold cycles.
// Ports:
//   clk   in : clock, rising edge
//   rst_n in : synchronous active-low reset
//   bus       : issue_ctrl_if.slave (if_valid, IR_IF in; issue, pc_we,
//               ifid_we, idex_bubble, hasHazard, br_hold, stall_cnt,
//               br_cnt out)
module issue_ctrl
  import cpu_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int BR_PENALTY = 2,
  parameter int CNT_W      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  issue_ctrl_if.slave  bus
);

  localparam int BL_W = (BR_PENALTY < 2) ? 1 : $clog2(BR_PENALTY + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  reg_idx_t rs, rt, wr_reg;
  logic     use_rs, use_rt, wr_en, is_branch;

  instr_decode u_decode (
    .ir        (bus.IR_IF),
    .rs        (rs),
    .rt        (rt),
    .use_rs    (use_rs),
    .use_rt    (use_rt),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .is_branch (is_branch)
  );

  sb_entry_t        sb_q [DEPTH];
  sb_entry_t        sb_d [DEPTH];
  issue_state_t     state_q, state_d;
  logic [BL_W-1:0]  br_left_q, br_left_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;

  logic has_hazard;
  logic issue;
  logic br_hold;

  // RAW check against every in-flight destination.
  always_comb begin
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_q[i].valid &&
          ((use_rs && (sb_q[i].dest == rs)) || (use_rt && (sb_q[i].dest == rt))))
        hit = 1'b1;
    end
    has_hazard = bus.if_valid && hit;
  end

  always_comb begin
    state_d   = state_q;
    br_left_d = br_left_q;
    issue     = 1'b0;
    br_hold   = 1'b0;
    case (state_q)
      ST_RUN: begin
        issue = bus.if_valid && !has_hazard;
        // A stalled branch only starts its penalty once it actually issues.
        if (issue && is_branch) begin
          state_d   = ST_BR_WAIT;
          br_left_d = BL_W'(BR_PENALTY);
        end
      end
      ST_BR_WAIT: begin
        br_hold   = 1'b1;
        br_left_d = br_left_q - BL_W'(1);
        if (br_left_q <= BL_W'(1))
          state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Scoreboard keeps shifting during holds so the bubbles drain it.
  always_comb begin
    sb_d[0].valid = issue && wr_en;
    sb_d[0].dest  = wr_reg;
    for (int i = 1; i < DEPTH; i++)
      sb_d[i] = sb_q[i-1];
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    br_cnt_d    = br_cnt_q;
    if ((state_q == ST_RUN) && has_hazard)
      stall_cnt_d = sat_inc(stall_cnt_q);
    if (state_q == ST_BR_WAIT)
      br_cnt_d = sat_inc(br_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        sb_q[i] <= '0;
      state_q     <= ST_RUN;
      br_left_q   <= '0;
      stall_cnt_q <= '0;
      br_cnt_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        sb_q[i] <= sb_d[i];
      state_q     <= state_d;
      br_left_q   <= br_left_d;
      stall_cnt_q <= stall_cnt_d;
      br_cnt_q    <= br_cnt_d;
    end
  end

  // An empty slot never blocks fetch.
  assign bus.issue       = issue;
  assign bus.pc_we       = issue || !bus.if_valid;
  assign bus.ifid_we     = issue || !bus.if_valid;
  assign bus.idex_bubble = !issue;
  assign bus.hasHazard   = has_hazard;
  assign bus.br_hold     = br_hold;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.br_cnt      = br_cnt_q;

endmodule
